// File: rtl/slice_pack_pkg.sv
// Shared definitions for the slice packer: FSM state encoding and width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package slice_pack_pkg;

    // COLLECT: gathering slices; FULL: a packed word is waiting at the output.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_e;

    // Ceiling log2. Returns 0 for values <= 1.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a slot index into NUM_SLICES slots. Never less than one bit.
    function automatic int idx_width_f(input int n);
        return (n <= 1) ? 1 : clog2_f(n);
    endfunction

endpackage

// File: rtl/slice_index_counter.sv
// Slot index for the slice packer: counts accepted slices within the current word.
// Latency: idx_o updates on the clock edge after inc_i/clear_i.
// Backpressure: none; inc_i is only raised on an accepted, non-closing slice.
//
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   inc_i        : advance to the next slot
//   clear_i      : return to slot 0 (applied before inc_i when both are set)
//   idx_o        : current slot index, 0..NUM_SLICES-1
//   at_last_o    : idx_o is the top slot
module slice_index_counter
    import slice_pack_pkg::*;
#(
    parameter int NUM_SLICES = 3,
    localparam int IW = idx_width_f(NUM_SLICES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          clear_i,
    output logic [IW-1:0] idx_o,
    output logic          at_last_o
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end
        // Saturate at the top slot; the word closes there and clear_i takes over.
        if (inc_i && (idx_d != LAST_IDX)) begin
            idx_d = idx_d + IW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o     = idx_q;
    assign at_last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/slice_packer.sv
// Width up-converter: packs SLICE_W-bit slices (first slice in LSBs) into one OUT_W word.
// Latency: out_valid rises one cycle after the closing slice is accepted; 1 slice/cycle sustained.
// Backpressure: while a word is pending, in_ready follows out_ready combinationally (no bubble).
//
// Ports:
//   clock, reset         : clock and synchronous active-high reset
//   in_valid/in_ready    : slice handshake; in_data payload, in_last closes a short word
//   out_valid/out_ready  : packed word handshake
//   out_data             : slice k at bits [k*SLICE_W +: SLICE_W], unused upper slots zero
//   out_count            : number of valid slices in out_data
module slice_packer
    import slice_pack_pkg::*;
#(
    parameter int SLICE_W    = 2,
    parameter int NUM_SLICES = 3,
    localparam int OUT_W = SLICE_W * NUM_SLICES,
    localparam int CW    = clog2_f(NUM_SLICES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CW-1:0]      out_count
);

    localparam int IW = idx_width_f(NUM_SLICES);

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]     out_count_q, out_count_d;

    logic [IW-1:0]     idx;
    logic              at_last;
    logic              slice_acc;
    logic              word_acc;
    logic              closing;
    logic              idx_inc;
    logic [OUT_W-1:0]  merged;

    slice_index_counter #(
        .NUM_SLICES (NUM_SLICES)
    ) u_idx (
        .clock     (clock),
        .reset     (reset),
        .inc_i     (idx_inc),
        .clear_i   (closing),
        .idx_o     (idx),
        .at_last_o (at_last)
    );

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_COLLECT) ? 1'b1 : out_ready;
    assign slice_acc = in_valid && in_ready;
    assign word_acc  = out_valid && out_ready;
    assign closing   = slice_acc && (at_last || in_last);
    assign idx_inc   = slice_acc && !closing;

    // Accumulator with the incoming slice dropped into slot idx. Slots above idx
    // are forced to zero so a short word never carries stale data. In FULL the
    // accumulator is already clear and idx is 0, so the same path loads slot 0.
    always_comb begin
        merged = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (k < int'(idx)) begin
                merged[k*SLICE_W +: SLICE_W] = acc_q[k*SLICE_W +: SLICE_W];
            end else if (k == int'(idx)) begin
                merged[k*SLICE_W +: SLICE_W] = in_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (closing) begin
            // Legal from COLLECT, or from FULL when the pending word leaves this cycle.
            state_d     = ST_FULL;
            out_data_d  = merged;
            out_count_d = CW'(idx) + CW'(1);
            acc_d       = '0;
        end else if (slice_acc) begin
            state_d = ST_COLLECT;
            acc_d   = merged;
        end else if (word_acc) begin
            state_d = ST_COLLECT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_slice_packer.sv
// Self-checking bench for slice_packer (SLICE_W=2, NUM_SLICES=3): directed scenarios plus
// randomized traffic scored against a slice-queue reference model.
// Inputs change 1 time unit after the rising edge; outputs sampled then or at the falling edge.
module tb_slice_packer;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic [1:0] out_count;

    int checks;
    int failures;

    slice_packer #(
        .SLICE_W    (2),
        .NUM_SLICES (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'b11;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 6'b000000) begin
            failures++;
            $display("FAIL reset_out_data: got %b expected 000000", out_data);
        end
        checks++;
        if (out_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_out_count: got %0d expected 0", out_count);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_full_word();
        logic [1:0] sl [3];
        sl[0] = 2'b01; sl[1] = 2'b10; sl[2] = 2'b11;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = sl[i];
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 6'b111001 || out_count !== 2'd3) begin
            failures++;
            $display("FAIL full_word: got v=%b d=%b c=%0d expected v=1 d=111001 c=3",
                     out_valid, out_data, out_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_word_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_last();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'b11;
        in_last   = 1'b0;
        step();
        in_data = 2'b01;
        in_last = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 6'b000111 || out_count !== 2'd2) begin
            failures++;
            $display("FAIL last_short_word: got v=%b d=%b c=%0d expected v=1 d=000111 c=2",
                     out_valid, out_data, out_count);
        end
        step();
        // Single-slice word: proves the index restarted at slot 0.
        in_valid = 1'b1;
        in_data  = 2'b10;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 6'b000010 || out_count !== 2'd1) begin
            failures++;
            $display("FAIL last_one_slice: got v=%b d=%b c=%0d expected v=1 d=000010 c=1",
                     out_valid, out_data, out_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_last   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 2'b01;
            step();
        end
        in_data = 2'b11;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 6'b010101) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b d=%b expected rdy=0 v=1 d=010101",
                         i, in_ready, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        in_data   = 2'b10;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release_rdy: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_after_accept: got out_valid=%b expected 0", out_valid);
        end
        in_valid = 1'b1;
        in_data  = 2'b00;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 6'b000010 || out_count !== 2'd2) begin
            failures++;
            $display("FAIL backpressure_slot0: got v=%b d=%b c=%0d expected v=1 d=000010 c=2",
                     out_valid, out_data, out_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] sl [6];
        sl[0] = 2'b01; sl[1] = 2'b01; sl[2] = 2'b01;
        sl[3] = 2'b10; sl[4] = 2'b10; sl[5] = 2'b10;
        out_ready = 1'b1;
        in_last   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = sl[i];
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            step();
            if (i == 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 6'b010101 || out_count !== 2'd3) begin
                    failures++;
                    $display("FAIL b2b_word0: got v=%b d=%b c=%0d expected v=1 d=010101 c=3",
                             out_valid, out_data, out_count);
                end
            end
            if (i == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 6'b101010 || out_count !== 2'd3) begin
                    failures++;
                    $display("FAIL b2b_word1: got v=%b d=%b c=%0d expected v=1 d=101010 c=3",
                             out_valid, out_data, out_count);
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midword();
        logic [1:0] sl [3];
        sl[0] = 2'b11; sl[1] = 2'b00; sl[2] = 2'b01;
        out_ready = 1'b1;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 2'b10;
        step();
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midword_reset_valid: got %b expected 0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = sl[i];
            step();
            if (i < 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL midword_early_word[%0d]: got out_valid=%b expected 0", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 6'b010011 || out_count !== 2'd3) begin
            failures++;
            $display("FAIL midword_word: got v=%b d=%b c=%0d expected v=1 d=010011 c=3",
                     out_valid, out_data, out_count);
        end
        step();
    endtask

    // Reference model: slices are collected in a queue; a word closes when it holds
    // three slices or the slice carries in_last. Closed words wait in an expected queue
    // until the output handshake consumes them.
    task automatic test_random();
        logic [1:0] cur [$];
        logic [5:0] exp_d [$];
        logic [1:0] exp_c [$];
        logic [5:0] w;

        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clock);
            #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 2'($urandom_range(0, 3));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clock);

            checks++;
            if (out_valid !== (exp_d.size() != 0)) begin
                failures++;
                $display("FAIL rand_valid cyc=%0d: got %b expected %b", cyc, out_valid, exp_d.size() != 0);
            end
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                failures++;
                $display("FAIL rand_in_ready cyc=%0d: got %b expected %b", cyc, in_ready, !out_valid || out_ready);
            end

            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_d.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra_word cyc=%0d: got d=%b with no word expected", cyc, out_data);
                end else begin
                    if (out_data !== exp_d[0] || out_count !== exp_c[0]) begin
                        failures++;
                        $display("FAIL rand_word cyc=%0d: got d=%b c=%0d expected d=%b c=%0d",
                                 cyc, out_data, out_count, exp_d[0], exp_c[0]);
                    end
                    void'(exp_d.pop_front());
                    void'(exp_c.pop_front());
                end
            end

            if (in_valid && in_ready === 1'b1) begin
                cur.push_back(in_data);
                if (cur.size() == 3 || in_last) begin
                    w = '0;
                    for (int i = 0; i < cur.size(); i++) begin
                        w = w | (6'(cur[i]) << (2 * i));
                    end
                    exp_d.push_back(w);
                    exp_c.push_back(2'(cur.size()));
                    cur.delete();
                end
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || exp_d.size() > 1) begin
            failures++;
            $display("FAIL rand_drain: got out_valid=%b pending_model=%0d expected 0/<=1",
                     out_valid, exp_d.size());
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 2'b00;
        in_last   = 1'b0;
        out_ready = 1'b0;

        test_reset();
        test_full_word();
        test_last();
        test_backpressure();
        test_back_to_back();
        test_reset_midword();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
